// File: rtl/bus_transfer_controller.sv
// bus_transfer_controller: round-robin sequencer for register-to-register moves on the shared internal bus
// Ports: register_clock/register_reset (async, active-high); req_valid/req_src/req_dst from two requesters
// (0 = control unit, 1 = I/O-debug), req_ready accept strobe; bus_out_en/bus_in_en one-hot registered
// register enables; xfer_done/xfer_err completion pulses; xfer_owner requester of current/last move; busy.
module bus_transfer_controller #(
  parameter int NUM_REGS = 8,
  parameter int SEL_W = 3
) (
  input  logic                  register_clock,
  input  logic                  register_reset,
  input  logic [1:0]            req_valid,
  input  logic [2*SEL_W-1:0]    req_src,
  input  logic [2*SEL_W-1:0]    req_dst,
  output logic [1:0]            req_ready,
  output logic [NUM_REGS-1:0]   bus_out_en,
  output logic [NUM_REGS-1:0]   bus_in_en,
  output logic                  xfer_done,
  output logic                  xfer_err,
  output logic                  xfer_owner,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, DRIVE, LATCH, RELEASE} state_t;
  localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};
  state_t state, nxt;
  logic last_grant, grant, accept, bad, err;
  logic [SEL_W-1:0] src, dst, sel_src, sel_dst, nsrc;
  always_comb begin
    grant = &req_valid ? ~last_grant : req_valid[1];
    accept = state == IDLE && |req_valid;
    sel_src = grant ? req_src[SEL_W +: SEL_W] : req_src[0 +: SEL_W];
    sel_dst = grant ? req_dst[SEL_W +: SEL_W] : req_dst[0 +: SEL_W];
    bad = 32'(sel_src) >= NUM_REGS || 32'(sel_dst) >= NUM_REGS || sel_src == sel_dst;
    req_ready = accept ? {grant, ~grant} : 2'b00;
    nxt = state == IDLE ? (accept ? (bad ? RELEASE : DRIVE) : IDLE) :
          state == DRIVE ? LATCH : state == LATCH ? RELEASE : IDLE;
    // enables are registered, so decode them from the source that will be current after this edge
    nsrc = accept ? sel_src : src;
  end
  assign busy = state != IDLE;
  always_ff @(posedge register_clock or posedge register_reset)
    if (register_reset) begin
      state <= IDLE;
      src <= '0;
      dst <= '0;
      err <= 1'b0;
      last_grant <= 1'b1;
      xfer_owner <= 1'b0;
      bus_out_en <= '0;
      bus_in_en <= '0;
      xfer_done <= 1'b0;
      xfer_err <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        src <= sel_src;
        dst <= sel_dst;
        xfer_owner <= grant;
        last_grant <= grant;
      end
      err <= accept ? bad : (state == RELEASE ? 1'b0 : err);
      bus_out_en <= nxt == DRIVE || nxt == LATCH ? ONE << nsrc : '0;
      bus_in_en <= nxt == LATCH ? ONE << dst : '0;
      xfer_done <= nxt == RELEASE;
      xfer_err <= nxt == RELEASE && (accept ? bad : err);
    end
endmodule
